// File: rtl/stream_tagger_pkg.sv
// Shared definitions for the tagger and the downstream filter stage:
// tag codes, word widths and the FSM state encoding.
package stream_tagger_pkg;

    localparam int TAG_W       = 2;
    localparam int PIX_W       = 8;
    localparam int DATA_W      = PIX_W + TAG_W;
    localparam int DIM_W       = 10;
    localparam int FLUSH_CNT_W = 20;

    localparam logic [TAG_W-1:0] TAG_INVALID = 2'd0;
    localparam logic [TAG_W-1:0] TAG_DATA0   = 2'd1;
    localparam logic [TAG_W-1:0] TAG_DATA1   = 2'd2;
    localparam logic [TAG_W-1:0] TAG_END     = 2'd3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CLEAR  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_FLUSH  = 2'd3;

endpackage

// File: rtl/stream_tagger_if.sv
// Control, pixel handshake and tagged-output bundle of the stream tagger.
// Handshake: a pixel transfers on a rising edge where pix_valid and pix_ready are both 1;
// pix_ready never depends on pix_valid, and the source holds pix_in stable while pix_valid=1.
interface stream_tagger_if
    import stream_tagger_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W
);
    logic                  start;
    logic [DIM_W-1:0]      image_width;
    logic [DIM_W-1:0]      image_height;
    logic [PIX_W-1:0]      pix_in;
    logic                  pix_valid;
    logic                  pix_ready;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  reflesh;
    logic                  busy;
    logic                  frame_done;
    logic [1:0]            state;

    modport master (
        output start, image_width, image_height, pix_in, pix_valid,
        input  pix_ready, data_out, reflesh, busy, frame_done, state
    );

    modport slave (
        input  start, image_width, image_height, pix_in, pix_valid,
        output pix_ready, data_out, reflesh, busy, frame_done, state
    );
endinterface

// File: rtl/stream_tagger_frame_counter.sv
// Column/row position of the next accepted pixel, with the flags the tagger needs
// to pick a tag for it.
module frame_counter
    import stream_tagger_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    input  logic [DIM_W-1:0] width,
    input  logic [DIM_W-1:0] height,
    output logic             last_pixel,
    output logic             odd_row
);
    logic [DIM_W-1:0] col;
    logic [DIM_W-1:0] row;
    logic             last_col;

    assign last_col   = (col == width - DIM_W'(1));
    assign last_pixel = last_col && (row == height - DIM_W'(1));
    assign odd_row    = row[0];

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (last_col) begin
                col <= '0;
                row <= row + DIM_W'(1);
            end else begin
                col <= col + DIM_W'(1);
            end
        end
    end
endmodule

// File: rtl/stream_tagger.sv
// Frames a raw pixel stream into tagged words for the window filter: clears the filter,
// tags pixels by row parity / end of frame, then flushes the filter pipeline.
module stream_tagger
    import stream_tagger_pkg::*;
#(
    parameter int                   TAG_WIDTH    = TAG_W,
    parameter logic [TAG_WIDTH-1:0] INVALID_TAG  = TAG_INVALID,
    parameter logic [TAG_WIDTH-1:0] DATA_TAG0    = TAG_DATA0,
    parameter logic [TAG_WIDTH-1:0] DATA_TAG1    = TAG_DATA1,
    parameter logic [TAG_WIDTH-1:0] DATA_END_TAG = TAG_END,
    parameter int                   OPE_WIDTH    = 3,
    parameter int                   FLUSH_EXTRA  = 8,
    parameter int                   DATA_WIDTH   = 8 + TAG_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    stream_tagger_if.slave  bus
);
    logic [1:0]             state;
    logic [DIM_W-1:0]       width_q;
    logic [DIM_W-1:0]       height_q;
    logic [FLUSH_CNT_W-1:0] flush_cnt;
    logic [FLUSH_CNT_W-1:0] flush_len;
    logic                   accept;
    logic                   start_ok;
    logic                   last_pixel;
    logic                   odd_row;
    logic [TAG_WIDTH-1:0]   tag;
    logic [DATA_WIDTH-1:0]  pixel_word;
    logic [DATA_WIDTH-1:0]  invalid_word;

    assign bus.pix_ready = (state == ST_STREAM);
    assign bus.state     = state;
    assign accept        = bus.pix_ready && bus.pix_valid;
    assign start_ok      = bus.start && (bus.image_width != '0) && (bus.image_height != '0);
    assign flush_len     = FLUSH_CNT_W'(width_q) * FLUSH_CNT_W'(OPE_WIDTH - 1)
                         + FLUSH_CNT_W'(FLUSH_EXTRA);

    always_comb begin
        tag = DATA_TAG0;
        if (last_pixel)   tag = DATA_END_TAG;
        else if (odd_row) tag = DATA_TAG1;
    end

    assign pixel_word   = {tag, bus.pix_in};
    assign invalid_word = {INVALID_TAG, 8'h00};

    frame_counter u_frame_counter (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == ST_IDLE),
        .advance    (accept),
        .width      (width_q),
        .height     (height_q),
        .last_pixel (last_pixel),
        .odd_row    (odd_row)
    );

    // The END word is output in the first FLUSH cycle; flush_len INVALID words follow it,
    // and frame_done rises in the cycle after the last of them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= ST_IDLE;
            width_q        <= '0;
            height_q       <= '0;
            flush_cnt      <= '0;
            bus.data_out   <= '0;
            bus.reflesh    <= 1'b0;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.data_out   <= invalid_word;
            bus.reflesh    <= 1'b0;
            bus.frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        width_q     <= bus.image_width;
                        height_q    <= bus.image_height;
                        state       <= ST_CLEAR;
                        bus.reflesh <= 1'b1;
                        bus.busy    <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (accept) begin
                        bus.data_out <= pixel_word;
                        if (last_pixel) begin
                            state     <= ST_FLUSH;
                            flush_cnt <= '0;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == flush_len) begin
                        state          <= ST_IDLE;
                        bus.busy       <= 1'b0;
                        bus.frame_done <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + FLUSH_CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
